// File: rtl/priority_decoder_3_to_8_hold.sv
// priority_decoder_3_to_8_hold
//
// Takes an encoded {index, valid} word from the 8-to-3 priority encoder
// through a valid/ready handshake. It turns the winning index back into a
// one-hot grant and holds that grant for HOLD_CYCLES clocks. No input is
// buffered. A new grant can be accepted on the last held cycle of the current
// grant, so back-to-back grants have no idle gap between them.
//
// Ports
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous reset, active-high
//   in_idx      in   IN_W   encoded index
//   in_valid    in   1      in_idx is valid
//   in_ready    out  1      index is accepted this cycle when in_valid is high
//   out_onehot  out  OUT_W  registered one-hot grant (1 << idx), 0 when idle
//   out_valid   out  1      a grant is being held
//   out_done    out  1      high on the final held cycle of a grant
//
// States
//   state | meaning
//   IDLE  | no grant; out_onehot = 0; ready for a new index
//   HOLD  | grant held; cnt counts the remaining cycles down to 0 (last cycle)

module priority_decoder_3_to_8_hold #(
  parameter int IN_W        = 3,
  parameter int OUT_W       = 1 << IN_W,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_idx,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_onehot,
  output logic             out_valid,
  output logic             out_done
);

  localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [OUT_W-1:0] onehot_q, onehot_nxt;
  logic             last_cycle;
  logic             accept;

  // Readiness comes from the state and the count only, so no combinational
  // path goes from in_valid to in_ready.
  assign last_cycle = (state == HOLD) && (cnt == '0);
  assign in_ready   = (state == IDLE) || last_cycle;
  assign accept     = in_valid && in_ready;

  assign out_onehot = onehot_q;
  assign out_valid  = (state == HOLD);
  assign out_done   = last_cycle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      onehot_q <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      onehot_q <= onehot_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    onehot_nxt = onehot_q;
    if (accept) begin
      // in_idx is sampled only here, so an X on an idle bus never reaches
      // the grant register.
      state_nxt  = HOLD;
      cnt_nxt    = CNT_LOAD;
      onehot_nxt = OUT_W'(1) << in_idx;
    end else if (state == HOLD) begin
      if (cnt != '0) begin
        cnt_nxt = cnt - 1'b1;
      end else begin
        state_nxt  = IDLE;
        onehot_nxt = '0;
      end
    end
  end

endmodule

// File: tb/tb_priority_decoder_3_to_8_hold.sv
module tb_priority_decoder_3_to_8_hold;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_idx;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_onehot;
  logic       out_valid;
  logic       out_done;

  logic [2:0] in_idx_h1;
  logic       in_valid_h1;
  logic       in_ready_h1;
  logic [7:0] out_onehot_h1;
  logic       out_valid_h1;
  logic       out_done_h1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  priority_decoder_3_to_8_hold #(.IN_W(3), .OUT_W(8), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .in_idx(in_idx), .in_valid(in_valid),
    .in_ready(in_ready), .out_onehot(out_onehot), .out_valid(out_valid),
    .out_done(out_done)
  );

  priority_decoder_3_to_8_hold #(.IN_W(3), .OUT_W(8), .HOLD_CYCLES(1)) dut_h1 (
    .clk(clk), .rst(rst), .in_idx(in_idx_h1), .in_valid(in_valid_h1),
    .in_ready(in_ready_h1), .out_onehot(out_onehot_h1), .out_valid(out_valid_h1),
    .out_done(out_done_h1)
  );

  // Advance one clock. Sampling happens 1 time unit after the rising edge.
  // Structural invariants of the HOLD_CYCLES=4 instance are checked on every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst) begin
      total++;
      if (!((out_onehot == 8'h00) || ($countones(out_onehot) == 1))) begin
        bad++;
        $display("FAIL inv_onehot got=%h want=zero_or_one_hot", out_onehot);
      end
      total++;
      if (out_valid !== (out_onehot != 8'h00)) begin
        bad++;
        $display("FAIL inv_valid got=%b want=%b", out_valid, (out_onehot != 8'h00));
      end
      total++;
      if (out_done && !out_valid) begin
        bad++;
        $display("FAIL inv_done_valid got done=%b valid=%b want done->valid", out_done, out_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_idx = 3'd5;
    in_valid_h1 = 1'b0; in_idx_h1 = 3'd0;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (out_onehot !== 8'h00) begin bad++; $display("FAIL reset_onehot got=%h want=00", out_onehot); end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      total++;
      if (out_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", out_done); end
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    total++;
    if (in_ready_h1 !== 1'b1) begin bad++; $display("FAIL reset_ready_h1 got=%b want=1", in_ready_h1); end
  endtask

  task automatic test_single();
    in_idx = 3'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (out_onehot !== 8'h08) begin bad++; $display("FAIL single_onehot c%0d got=%h want=08", k, out_onehot); end
      total++;
      if (out_done !== (k == 4)) begin bad++; $display("FAIL single_done c%0d got=%b want=%b", k, out_done, (k == 4)); end
      total++;
      if (in_ready !== (k == 4)) begin bad++; $display("FAIL single_ready c%0d got=%b want=%b", k, in_ready, (k == 4)); end
      tick();
    end
    total++;
    if (out_onehot !== 8'h00) begin bad++; $display("FAIL single_end_onehot got=%h want=00", out_onehot); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL single_end_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    in_idx = 3'd7; in_valid = 1'b1;
    tick();
    in_idx = 3'd0;
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (out_onehot !== 8'h80) begin bad++; $display("FAIL b2b_first c%0d got=%h want=80", k, out_onehot); end
      total++;
      if (in_ready !== (k == 4)) begin bad++; $display("FAIL b2b_ready c%0d got=%b want=%b", k, in_ready, (k == 4)); end
      total++;
      if (out_done !== (k == 4)) begin bad++; $display("FAIL b2b_done c%0d got=%b want=%b", k, out_done, (k == 4)); end
      tick();
    end
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (out_onehot !== 8'h01) begin bad++; $display("FAIL b2b_second c%0d got=%h want=01", k, out_onehot); end
      total++;
      if (out_done !== (k == 4)) begin bad++; $display("FAIL b2b_done2 c%0d got=%b want=%b", k, out_done, (k == 4)); end
      tick();
    end
    total++;
    if (out_onehot !== 8'h00) begin bad++; $display("FAIL b2b_end got=%h want=00", out_onehot); end
  endtask

  task automatic test_stall();
    in_idx = 3'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    in_idx = 3'd2; in_valid = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      total++;
      if (out_onehot !== 8'h02) begin bad++; $display("FAIL stall_hold c%0d got=%h want=02", k, out_onehot); end
      total++;
      if (in_ready !== (k == 4)) begin bad++; $display("FAIL stall_ready c%0d got=%b want=%b", k, in_ready, (k == 4)); end
      tick();
    end
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (out_onehot !== 8'h04) begin bad++; $display("FAIL stall_grant c%0d got=%h want=04", k, out_onehot); end
      total++;
      if (out_done !== (k == 4)) begin bad++; $display("FAIL stall_done c%0d got=%b want=%b", k, out_done, (k == 4)); end
      tick();
    end
    total++;
    if (out_onehot !== 8'h00) begin bad++; $display("FAIL stall_end got=%h want=00", out_onehot); end
  endtask

  task automatic test_reset_mid_hold();
    in_idx = 3'd6; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    total++;
    if (out_onehot !== 8'h40) begin bad++; $display("FAIL rstmid_pre got=%h want=40", out_onehot); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (out_onehot !== 8'h00) begin bad++; $display("FAIL rstmid_onehot got=%h want=00", out_onehot); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", out_valid); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", in_ready); end
    total++;
    if (out_done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", out_done); end
    tick();
    total++;
    if (out_onehot !== 8'h00) begin bad++; $display("FAIL rstmid_after got=%h want=00", out_onehot); end
  endtask

  task automatic test_sweep_hold1();
    logic [7:0] exp;
    in_idx_h1 = 3'd0; in_valid_h1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 7) in_valid_h1 = 1'b0;
      else in_idx_h1 = 3'(i + 1);
      exp = 8'h01 << i;
      total++;
      if (out_onehot_h1 !== exp) begin bad++; $display("FAIL sweep_onehot i%0d got=%h want=%h", i, out_onehot_h1, exp); end
      total++;
      if (out_done_h1 !== 1'b1) begin bad++; $display("FAIL sweep_done i%0d got=%b want=1", i, out_done_h1); end
      total++;
      if (out_valid_h1 !== 1'b1) begin bad++; $display("FAIL sweep_valid i%0d got=%b want=1", i, out_valid_h1); end
      total++;
      if (in_ready_h1 !== 1'b1) begin bad++; $display("FAIL sweep_ready i%0d got=%b want=1", i, in_ready_h1); end
    end
    tick();
    total++;
    if (out_onehot_h1 !== 8'h00) begin bad++; $display("FAIL sweep_end got=%h want=00", out_onehot_h1); end
    total++;
    if (out_done_h1 !== 1'b0) begin bad++; $display("FAIL sweep_end_done got=%b want=0", out_done_h1); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid_hold();
    test_sweep_hold1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
